pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Parametrised forwarding and load-use hazard controller for the pipelined CPU, replacing the fixed two-operand, two-stage forwarding unit. It selects a forwarding source per EX operand across NUM_FWD downstream stages (nearest wins). It detects load-use hazards in ID and holds the front end for LOAD_LAT cycles under a small FSM. Saturating stall and forward event counters support performance measurement.

## Interface
- REG_W, 5: register index width
- NUM_SRC, 2: source operands per instruction
- NUM_FWD, 2: forwarding stages; index 0 = EX/MEM (nearest), index NUM_FWD-1 = oldest
- LOAD_LAT, 1: stall cycles per load-use hazard, ≥1
- CNT_W, 16: event counter width
- SEL_W, derived, clog2(NUM_FWD+1): per-operand select width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- hold  in  1  global pipeline freeze (memory wait); FSM and counters frozen
- flush  in  1  taken branch/jump; aborts a stall in progress
- id_src  in  NUM_SRC*REG_W  ID-stage source registers, operand i at [i*REG_W +: REG_W]
- id_src_used  in  NUM_SRC  operand i actually read by the ID instruction
- ex_src  in  NUM_SRC*REG_W  EX-stage source registers
- ex_memread  in  1  EX instruction is a load
- ex_wr  in  REG_W  EX destination register
- stg_regwrite  in  NUM_FWD  stage k writes a register
- stg_wr  in  NUM_FWD*REG_W  stage k destination
- cnt_clr  in  1  synchronous clear of both counters
- fwd_sel  out  NUM_SRC*SEL_W  operand i: 0 = register file, k = stage k-1
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- stall_cnt  out  CNT_W  cycles with stall=1
- fwd_cnt  out  CNT_W  cycles with any fwd_sel≠0

## Operation
- Forwarding, per operand i, combinational: scan k = 0..NUM_FWD-1 and take the lowest k where stg_regwrite[k], stg_wr[k]≠0 and stg_wr[k]==ex_src[i]. Then fwd_sel = k+1. If no stage matches, fwd_sel = 0. Register 0 is never forwarded.
- Hazard detect: det = ex_memread, ex_wr≠0, and some i with id_src_used[i] and id_src[i]==ex_wr.
- FSM states are IDLE and STALL, with down-counter rem (width clog2(LOAD_LAT+1)).
- IDLE: stall = det & ~flush.
  - If det & ~flush & ~hold & LOAD_LAT>1: go to STALL, rem = LOAD_LAT-1.
  - Otherwise stay in IDLE.
- STALL: stall = ~flush.
  - flush: go to IDLE and clear rem.
  - Else if ~hold: rem decrements; when rem==1, go to IDLE at that edge.
  - hold=1: state and rem unchanged.
- Net effect: each hazard yields exactly LOAD_LAT stall cycles that are not under hold.
- det is ignored while in STALL.
- Counters: on each edge with ~hold, stall_cnt increments if stall, and fwd_cnt increments if any fwd_sel≠0.
  - Both saturate at all-ones.
  - cnt_clr takes priority over increment and acts even under hold.
- Simultaneous flush and det: flush wins, no stall.

## Timing
- fwd_sel and stall are combinational, valid in the same cycle as their inputs. No registered latency.
- State, rem and counters update on the rising clk edge.
- Reset (rst=0) is asynchronous: state=IDLE, rem=0, stall_cnt=0, fwd_cnt=0.
  - stall=0 and fwd_sel=0 are forced while rst=0.
  - Deasserting reset during a would-be stall leaves the FSM in IDLE; det is re-evaluated from the current inputs.
- A stall entered with LOAD_LAT=1 never leaves IDLE. The next cycle sees a bubble in EX (ex_memread=0).

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (ST_IDLE, ST_STALL);
  - SEL_W and the rem width, computed with $clog2;
  - FWD_RF=0, the register-file select constant.
- Sub-module fwd_match holds one operand's priority encoder over NUM_FWD stages, with parameters REG_W, NUM_FWD, SEL_W. Instantiate it NUM_SRC times in a generate loop.
- The top level holds the hazard detect, the FSM, and the counters.

## Test plan
- Default parameters, 2 stages:
  - stg_wr = {5, 5}, both writing, ex_src = {5, 7} → fwd_sel operand0 = 1, operand1 = 0.
  - Then clear stg_regwrite[0] → operand0 = 2.
  - Set ex_src = 0 with stg_wr = 0 → fwd_sel = 0.
- LOAD_LAT=1: ex_memread=1, ex_wr=8, id_src[1]=8 used → stall=1 for exactly 1 cycle.
  - Same with id_src_used[1]=0 → stall=0.
- LOAD_LAT=3: hazard, then hold=1 on the second stall cycle for 2 cycles → stall high for 5 cycles, stall_cnt=3.
- LOAD_LAT=3: flush in the second stall cycle → stall=0 that cycle, FSM in IDLE next cycle. flush coincident with det → no stall.
- CNT_W=4: 20 cycles of continuous forwarding → fwd_cnt saturates at 15.
  - cnt_clr together with an event → 0.
  - Asynchronous rst pulse mid-STALL → counters 0, stall=0 immediately.
- NUM_SRC=3, NUM_FWD=4: random register indices versus a reference model, 10k cycles, checking fwd_sel and stall every cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and width helpers for the forwarding / load-use hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    // Select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    function automatic int sel_width(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

    function automatic int rem_width(input int load_lat);
        return $clog2(load_lat + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller; master drives the pipeline view.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
);
    localparam int SEL_W = sel_width(NUM_FWD);

    logic                       hold;
    logic                       flush;
    logic [NUM_SRC*REG_W-1:0]   id_src;
    logic [NUM_SRC-1:0]         id_src_used;
    logic [NUM_SRC*REG_W-1:0]   ex_src;
    logic                       ex_memread;
    logic [REG_W-1:0]           ex_wr;
    logic [NUM_FWD-1:0]         stg_regwrite;
    logic [NUM_FWD*REG_W-1:0]   stg_wr;
    logic                       cnt_clr;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
    logic                       stall;
    logic [CNT_W-1:0]           stall_cnt;
    logic [CNT_W-1:0]           fwd_cnt;

    modport master (
        output hold, flush, id_src, id_src_used, ex_src, ex_memread, ex_wr,
               stg_regwrite, stg_wr, cnt_clr,
        input  fwd_sel, stall, stall_cnt, fwd_cnt
    );

    modport slave (
        input  hold, flush, id_src, id_src_used, ex_src, ex_memread, ex_wr,
               stg_regwrite, stg_wr, cnt_clr,
        output fwd_sel, stall, stall_cnt, fwd_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Priority encoder for one EX operand: nearest writing stage with a matching
// nonzero destination wins.
module fwd_match
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = 2
) (
    input  logic [REG_W-1:0]         src_i,
    input  logic [NUM_FWD-1:0]       stg_regwrite_i,
    input  logic [NUM_FWD*REG_W-1:0] stg_wr_i,
    output logic [SEL_W-1:0]         sel_o
);

    // Walk from oldest to nearest so the nearest match is written last.
    always_comb begin
        sel_o = SEL_W'(FWD_RF);
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (stg_regwrite_i[k] &&
                (stg_wr_i[k*REG_W +: REG_W] != '0) &&
                (stg_wr_i[k*REG_W +: REG_W] == src_i)) begin
                sel_o = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Operand forwarding select, load-use stall FSM and saturating event counters.
// States: ST_IDLE = stall driven by live hazard detect; ST_STALL = remaining load latency.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int SEL_W = sel_width(NUM_FWD);
    localparam int REM_W = rem_width(LOAD_LAT);

    logic [NUM_SRC*SEL_W-1:0] fwd_sel_raw;
    logic                     det;
    logic                     stall_c;
    logic                     any_fwd;
    state_e                   state_q, state_d;
    logic [REM_W-1:0]         rem_q, rem_d;
    logic [CNT_W-1:0]         stall_cnt_q;
    logic [CNT_W-1:0]         fwd_cnt_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
        fwd_match #(
            .REG_W   (REG_W),
            .NUM_FWD (NUM_FWD),
            .SEL_W   (SEL_W)
        ) u_match (
            .src_i          (bus.ex_src[i*REG_W +: REG_W]),
            .stg_regwrite_i (bus.stg_regwrite),
            .stg_wr_i       (bus.stg_wr),
            .sel_o          (fwd_sel_raw[i*SEL_W +: SEL_W])
        );
    end

    always_comb begin
        det = 1'b0;
        if (bus.ex_memread && (bus.ex_wr != '0)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.id_src_used[i] && (bus.id_src[i*REG_W +: REG_W] == bus.ex_wr)) begin
                    det = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // A single-cycle load latency is fully covered by the IDLE stall, so STALL is never entered.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        stall_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_c = det && !bus.flush;
                if (det && !bus.flush && !bus.hold && (LOAD_LAT > 1)) begin
                    state_d = ST_STALL;
                    rem_d   = REM_W'(LOAD_LAT - 1);
                end
            end
            ST_STALL: begin
                stall_c = !bus.flush;
                if (bus.flush) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end else if (!bus.hold) begin
                    rem_d = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    assign bus.stall   = rst && stall_c;
    assign bus.fwd_sel = rst ? fwd_sel_raw : '0;
    assign any_fwd     = |bus.fwd_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else if (bus.cnt_clr) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else if (!bus.hold) begin
            if (bus.stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (any_fwd && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;

endmodule
